// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and helpers for the common-data-bus arbiter.
//   tag_w()      : tag width for a given ROB depth
//   cdb_entry_t  : {tag, data} result entry at the default ROB depth
package cdb_pkg;
  function automatic int tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int ROB_DEPTH_DEF = 8;
  localparam int TAG_W_DEF = tag_w(ROB_DEPTH_DEF);
  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [31:0]          data;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_req_fifo.sv
// cdb_req_fifo: per-FU result queue feeding the CDB arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empty the queue at the next edge, ignoring push/pop
//   push, din  : enqueue din when not full
//   pop        : dequeue the head when not empty
//   dout       : head entry (meaningless while empty)
//   full/empty : occupancy flags
module cdb_req_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = cdb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of N_PORT CDB broadcast ports among N_REQ FU result queues.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : drop every queued and output result at the next edge
//   fu_valid/fu_ready : per-FU result handshake (transfer = valid & ready)
//   fu_tag/fu_data    : per-FU offered ROB tag and value
//   valid_CDB         : per-port one-cycle broadcast strobe (registered)
//   tag_CDB/data_CDB  : per-port broadcast tag/value, held while idle
// Optional feature macro CDB_ARB_BYPASS_EN: an empty queue's offered entry competes in the
// same cycle and, if granted, goes straight to the output register.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_PORT = 2,
  parameter int ROB_DEPTH = 8,
  parameter int FIFO_DEPTH = 2,
  localparam int TAG_W = tag_w(ROB_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [N_REQ-1:0]              fu_valid,
  output logic [N_REQ-1:0]              fu_ready,
  input  logic [N_REQ-1:0][TAG_W-1:0]   fu_tag,
  input  logic [N_REQ-1:0][31:0]        fu_data,
  output logic [N_PORT-1:0]             valid_CDB,
  output logic [N_PORT-1:0][TAG_W-1:0]  tag_CDB,
  output logic [N_PORT-1:0][31:0]       data_CDB
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } entry_t;
  logic [PW-1:0] rr_ptr, rr_next;
  logic [N_REQ-1:0] full, empty, elig, gnt, push, pop;
  entry_t in_e [N_REQ];
  entry_t q_out [N_REQ];
  entry_t head [N_REQ];
  entry_t port_e [N_PORT];
  logic [N_PORT-1:0] port_v;
  int pos [N_REQ];
  int rank [N_REQ];
  int last_pos;
  assign fu_ready = ~full;
  assign pop = gnt & ~empty;
  for (genvar i = 0; i < N_REQ; i++) begin : g_q
    assign in_e[i] = {fu_tag[i], fu_data[i]};
`ifdef CDB_ARB_BYPASS_EN
    assign elig[i] = ~empty[i] | fu_valid[i];
    assign head[i] = empty[i] ? in_e[i] : q_out[i];
    // A granted offer on an empty queue is broadcast directly, so it must not also be enqueued.
    assign push[i] = fu_valid[i] & ~(empty[i] & gnt[i]);
`else
    assign elig[i] = ~empty[i];
    assign head[i] = q_out[i];
    assign push[i] = fu_valid[i];
`endif
    cdb_req_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_e[i]),
      .dout  (q_out[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  // pos = distance from rr_ptr in scan order; rank = eligible requesters scanned earlier.
  // The first N_PORT eligible requesters win, and rank selects the port.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) pos[i] = (i + N_REQ - int'(rr_ptr)) % N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      rank[i] = 0;
      for (int j = 0; j < N_REQ; j++) if (elig[j] && pos[j] < pos[i]) rank[i] = rank[i] + 1;
      gnt[i] = elig[i] && rank[i] < N_PORT;
    end
    port_v = '0;
    for (int k = 0; k < N_PORT; k++) begin
      port_e[k] = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && rank[i] == k) begin
          port_v[k] = 1'b1;
          port_e[k] = head[i];
        end
      end
    end
    rr_next = rr_ptr;
    last_pos = -1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i] && pos[i] > last_pos) begin
        last_pos = pos[i];
        rr_next = PW'((i + 1) % N_REQ);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      valid_CDB <= '0;
      tag_CDB <= '0;
      data_CDB <= '0;
    end else if (flush) begin
      valid_CDB <= '0;
    end else begin
      rr_ptr <= rr_next;
      valid_CDB <= port_v;
      for (int k = 0; k < N_PORT; k++) begin
        if (port_v[k]) begin
          tag_CDB[k] <= port_e[k].tag;
          data_CDB[k] <= port_e[k].data;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter (N_REQ=4, N_PORT=2, ROB_DEPTH=8, FIFO_DEPTH=2).
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [3:0] fu_valid = '0;
  logic [3:0] fu_ready;
  logic [3:0][2:0] fu_tag = '0;
  logic [3:0][31:0] fu_data = '0;
  logic [1:0] valid_CDB;
  logic [1:0][2:0] tag_CDB;
  logic [1:0][31:0] data_CDB;
  int n_chk = 0;
  int n_err = 0;
  int seq = 0;
  int gcnt [4];
  int f;
  logic [34:0] exp_q [4][$];
`ifdef CDB_ARB_BYPASS_EN
  localparam int D = 0;
`else
  localparam int D = 1;
`endif
  typedef struct {
    logic [3:0] v;
    logic [3:0][2:0] t;
    logic [1:0] ev;
    logic [1:0][2:0] et;
  } vec_t;
  vec_t vec [10];
  localparam logic [3:0][2:0] TAGS = {3'd3, 3'd2, 3'd1, 3'd0};

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .valid_CDB (valid_CDB),
    .tag_CDB   (tag_CDB),
    .data_CDB  (data_CDB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][2:0] t);
    fu_valid = v;
    fu_tag = t;
    for (int i = 0; i < 4; i++) fu_data[i] = {4'(i), 25'(seq), 3'b0};
    seq++;
  endtask

  function automatic vec_t mkv(logic [3:0] v, int t0, int t1, int t2, int t3, logic [1:0] ev, int e0, int e1);
    vec_t r;
    r.v = v;
    r.t = {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
    r.ev = ev;
    r.et = {3'(e1), 3'(e0)};
    return r;
  endfunction

  function automatic int total();
    int s = 0;
    for (int i = 0; i < 4; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Scoreboard: accepted pushes are queued per FU; every broadcast must match the head of some FU queue.
  // Queue occupancy also predicts fu_ready.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (valid_CDB[k]) begin
          f = -1;
          for (int i = 0; i < 4; i++)
            if (f < 0 && exp_q[i].size() > 0 && exp_q[i][0] == {tag_CDB[k], data_CDB[k]}) f = i;
          n_chk++;
          if (f < 0) begin
            n_err++;
            $display("FAIL sb_port%0d: got tag %0d data %h, expected a pending FU head entry", k, tag_CDB[k], data_CDB[k]);
          end else begin
            void'(exp_q[f].pop_front());
            gcnt[f]++;
          end
        end
      end
      for (int i = 0; i < 4; i++) chk($sformatf("ready_fu%0d", i), fu_ready[i], exp_q[i].size() != 2);
      for (int i = 0; i < 4; i++) begin
        if (flush) exp_q[i].delete();
        else if (fu_valid[i] && fu_ready[i]) exp_q[i].push_back({fu_tag[i], fu_data[i]});
      end
    end
  end

  initial begin
    vec[0] = mkv(4'b1111, 0, 1, 2, 3, 2'b11, 0, 1);
    vec[1] = mkv(4'b0000, 0, 0, 0, 0, 2'b11, 2, 3);
    vec[2] = mkv(4'b1011, 4, 5, 0, 6, 2'b11, 4, 5);
    vec[3] = mkv(4'b0000, 0, 0, 0, 0, 2'b01, 6, 0);
    vec[4] = mkv(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0);
    vec[5] = mkv(4'b0010, 0, 1, 0, 0, 2'b01, 1, 0);
    vec[6] = mkv(4'b0010, 0, 2, 0, 0, 2'b01, 2, 0);
    vec[7] = mkv(4'b0010, 0, 3, 0, 0, 2'b01, 3, 0);
    vec[8] = mkv(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0);
    vec[9] = mkv(4'b0000, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step;
    step;
    chk("rst_valid", valid_CDB, 2'b00);
    chk("rst_ready", fu_ready, 4'hF);
    chk("rst_tag", tag_CDB, '0);
    chk("rst_data", data_CDB, '0);
    for (int r = 0; r < 10; r++) begin
      int e;
      drive(vec[r].v, vec[r].t);
      step;
      e = r - D;
      if (e < 0) chk("vec_lead_idle", valid_CDB, 2'b00);
      else begin
        chk($sformatf("vec%0d_valid", e), valid_CDB, vec[e].ev);
        for (int k = 0; k < 2; k++)
          if (vec[e].ev[k]) chk($sformatf("vec%0d_tag%0d", e, k), tag_CDB[k], vec[e].et[k]);
      end
    end
    fu_valid = '0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      drive(4'hF, TAGS);
      step;
    end
    fu_valid = '0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (gcnt[i] < 9 || gcnt[i] > 11) begin
        n_err++;
        $display("FAIL fair_fu%0d: got %0d grants expected 9..11", i, gcnt[i]);
      end
    end
    for (int c = 0; c < 20 && total() > 0; c++) step;
    chk("drain_left", total(), 0);
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, TAGS);
      step;
    end
    flush = 1'b1;
    drive(4'hF, TAGS);
    step;
    chk("flush_valid", valid_CDB, 2'b00);
    chk("flush_ready", fu_ready, 4'hF);
    flush = 1'b0;
    fu_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step;
      chk($sformatf("post_flush_valid%0d", c), valid_CDB, 2'b00);
    end
    fu_valid = 4'b0100;
    fu_tag[2] = 3'd5;
    fu_data[2] = 32'hDEADBEEF;
    step;
    fu_valid = '0;
`ifdef CDB_ARB_BYPASS_EN
    chk("byp_valid", valid_CDB, 2'b01);
    chk("byp_tag", tag_CDB[0], 3'd5);
    chk("byp_data", data_CDB[0], 32'hDEADBEEF);
    step;
    chk("byp_pulse", valid_CDB, 2'b00);
`else
    chk("lat_edge_t", valid_CDB, 2'b00);
    step;
    chk("lat_valid", valid_CDB, 2'b01);
    chk("lat_tag", tag_CDB[0], 3'd5);
    chk("lat_data", data_CDB[0], 32'hDEADBEEF);
`endif
    step;
    chk("hold_valid", valid_CDB, 2'b00);
    chk("hold_tag", tag_CDB[0], 3'd5);
    chk("hold_data", data_CDB[0], 32'hDEADBEEF);
    drive(4'hF, TAGS);
    step;
    step;
    fu_valid = '0;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid_CDB, 2'b00);
    chk("arst_ready", fu_ready, 4'hF);
    chk("arst_tag", tag_CDB, '0);
    chk("arst_data", data_CDB, '0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step;
    step;
    chk("post_rst_valid", valid_CDB, 2'b00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
